fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Program counter and fetch sequencer directly upstream of the control decoder.
- Drives the instruction ROM address. Consumes the decoder's branch_en and ctrl_ack_out to choose the next PC.
- Branch targets come from a small lookup table, indexed by the low bits of the current break instruction and loaded before the run starts.
- Provides the start/done handshake to the testbench or top level.

Parameters:
- PC_W, 10, width of the program counter / instruction ROM address.
- LUT_AW, 3, address width of the branch target table (2^LUT_AW entries of PC_W bits).

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  begin (or restart) execution; level-sampled in IDLE/DONE.
- start_addr  input  PC_W  PC loaded on an accepted start.
- stall  input  1  hold PC this cycle while RUN.
- branch_en  input  1  from decoder: take branch.
- branch_idx  input  LUT_AW  table index, wired to instruction[LUT_AW-1:0].
- ctrl_ack_out  input  1  from decoder: halt instruction present.
- lut_we  input  1  table write strobe (IDLE/DONE only).
- lut_addr  input  LUT_AW  table write address.
- lut_data  input  PC_W  table write data.
- pc  output  PC_W  current fetch address to the instruction ROM.
- running  output  1  high in RUN.
- done  output  1  high in DONE.
- cycle_cnt  output  16  RUN-cycle counter (optional feature).
- branch_cnt  output  16  taken-branch counter (optional feature).

Behaviour:
- Reset (async assert, reset_n=0):
  - state=IDLE, pc=0, running=0, done=0, all table entries=0, counters=0.
  - Release is synchronous to clk.
- Registered state machine with states IDLE, RUN, DONE.
- IDLE:
  - lut_we writes lut_data into table[lut_addr] at the edge.
  - start=1 loads pc<=start_addr and moves to RUN at the next edge.
  - Otherwise pc holds.
- RUN (running=1), per-edge priority:
  1. stall=1: pc holds, no state change.
  2. ctrl_ack_out=1: pc holds and state goes to DONE. Halt beats a simultaneous branch_en.
  3. branch_en=1: pc<=table[branch_idx].
  4. Otherwise pc<=pc+1, modulo 2^PC_W (max value wraps to 0, no flag).
- RUN ignores lut_we and start.
- DONE:
  - done=1, pc holds the halt address.
  - lut_we is allowed.
  - start=1 loads pc<=start_addr, clears done and enters RUN at the next edge. done is low the cycle RUN is entered.
- Table read is combinational. A write to the entry being read is visible only after the edge.
- The instruction ROM is combinational on pc, so decoder inputs are valid in the same cycle as pc. PC update latency is one clock.
- running and done are registered, decoded from state, and never high together.
- Reset mid-run returns immediately to IDLE with pc=0. Table contents are lost.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined:
  - cycle_cnt increments every clk edge while in RUN, including stalled cycles.
  - branch_cnt increments on each taken branch (RUN, no stall, branch_en=1, ctrl_ack_out=0).
  - Both saturate at 16'hFFFF.
  - Both clear on an accepted start and on reset.
- Not defined: cycle_cnt and branch_cnt are tied to 0 and no counter flops are built.

Test Plan:
- Reset + linear run:
  - reset_n low, then high.
  - start=1 with start_addr=10'd5.
  - No branches, stall=0.
  - Expect pc 5,6,7,8 on successive edges, running=1, done=0.
- Branch:
  - In IDLE write table[3]=10'd100.
  - Run from 0; at pc=2 drive branch_en=1, branch_idx=3.
  - Expect next pc=100, then 101.
  - With FETCH_PERF_CNT_EN: branch_cnt=1.
- Halt priority:
  - At pc=7 assert ctrl_ack_out=1 and branch_en=1 together.
  - Expect pc stays 7, done=1, running=0.
  - Further edges keep pc=7.
- Stall:
  - Assert stall for 3 cycles at pc=4, with branch_en=1 during the stall.
  - Expect pc=4 throughout; then pc=5 after release with branch_en=0.
  - With FETCH_PERF_CNT_EN: the 3 stalled cycles are counted in cycle_cnt.
- Wrap and restart:
  - start_addr=10'h3FF, no branch.
  - Expect pc 3FF then 000.
  - Halt, then start with start_addr=10'd20 from DONE.
  - Expect done=0 and pc=20; counters clear.
- Async reset mid-run:
  - Pull reset_n low between edges while pc=50.
  - Expect pc=0, state IDLE, table entries 0, without waiting for clk.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch-unit bus: run control, decoder feedback, branch-table load port and PC/status outputs.
interface fetch_unit_if #(
  parameter int PC_W   = 10,
  parameter int LUT_AW = 3
);
  logic              start;
  logic [PC_W-1:0]   start_addr;
  logic              stall;
  logic              branch_en;
  logic [LUT_AW-1:0] branch_idx;
  logic              ctrl_ack_out;
  logic              lut_we;
  logic [LUT_AW-1:0] lut_addr;
  logic [PC_W-1:0]   lut_data;
  logic [PC_W-1:0]   pc;
  logic              running;
  logic              done;
  logic [15:0]       cycle_cnt;
  logic [15:0]       branch_cnt;

  modport master (
    output start, start_addr, stall, branch_en, branch_idx, ctrl_ack_out,
           lut_we, lut_addr, lut_data,
    input  pc, running, done, cycle_cnt, branch_cnt
  );

  modport slave (
    input  start, start_addr, stall, branch_en, branch_idx, ctrl_ack_out,
           lut_we, lut_addr, lut_data,
    output pc, running, done, cycle_cnt, branch_cnt
  );
endinterface

// File: rtl/fetch_unit.sv
// PC / fetch sequencer with IDLE-RUN-DONE control and a loadable branch-target table.
// Define FETCH_PERF_CNT_EN to build the saturating RUN-cycle and taken-branch counters.
module fetch_unit #(
  parameter int PC_W   = 10,
  parameter int LUT_AW = 3
) (
  input  logic         clk,
  input  logic         reset_n,
  fetch_unit_if.slave  bus
);
  localparam int LUT_N = 1 << LUT_AW;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;

  state_e                      state_q, state_d;
  logic [PC_W-1:0]             pc_q, pc_d;
  logic [LUT_N-1:0][PC_W-1:0]  lut_q;

  logic in_run, advance, start_acc, br_take;

  assign in_run    = (state_q == RUN);
  assign advance   = in_run && !bus.stall && !bus.ctrl_ack_out;
  assign start_acc = !in_run && bus.start;
  assign br_take   = advance && bus.branch_en;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (bus.start) state_d = RUN;
      RUN:        if (!bus.stall && bus.ctrl_ack_out) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.running = (state_q == RUN);
    bus.done    = (state_q == DONE);
  end

  // Halt leaves the PC on the halt instruction; stall beats everything.
  always_comb begin
    pc_d = pc_q;
    if (start_acc)    pc_d = bus.start_addr;
    else if (br_take) pc_d = lut_q[bus.branch_idx];
    else if (advance) pc_d = pc_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pc_q <= '0;
    else          pc_q <= pc_d;
  end

  assign bus.pc = pc_q;

  // Table is frozen while running so a branch never races a load.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                lut_q <= '0;
    else if (bus.lut_we && !in_run) lut_q[bus.lut_addr] <= bus.lut_data;
  end

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] cyc_q, brc_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cyc_q <= '0;
      brc_q <= '0;
    end else if (start_acc) begin
      cyc_q <= '0;
      brc_q <= '0;
    end else begin
      if (in_run && cyc_q != 16'hFFFF)  cyc_q <= cyc_q + 16'd1;
      if (br_take && brc_q != 16'hFFFF) brc_q <= brc_q + 16'd1;
    end
  end

  assign bus.cycle_cnt  = cyc_q;
  assign bus.branch_cnt = brc_q;
`else
  assign bus.cycle_cnt  = 16'd0;
  assign bus.branch_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed plan steps followed by random traffic.
module tb_fetch_unit;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if #(.PC_W(10), .LUT_AW(3)) bus ();
  fetch_unit #(.PC_W(10), .LUT_AW(3)) dut (.clk(clk), .reset_n(reset_n), .bus(bus.slave));

  typedef struct {
    int pc; bit run; bit dn; int cc; int bc; int step;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int errs = 0, checks = 0, step = 0;

  // Reference model: mode 0 idle, 1 running, 2 done
  int mmode, mpc, mcc, mbc;
  int mlut[8];

  task automatic chk(input string nm, input int stp, input int got, input int want);
    checks++;
    if (got != want) begin
      errs++;
      $display("FAIL %s step%0d: got %0h expected %0h", nm, stp, got, want);
    end
  endtask

  task automatic model_reset();
    mmode = 0; mpc = 0; mcc = 0; mbc = 0;
    for (int i = 0; i < 8; i++) mlut[i] = 0;
  endtask

  task automatic drive(input bit st, input int sa, input bit sl, input bit br, input int bi,
                       input bit ak, input bit we, input int wa, input int wd);
    exp_t x;
    @(negedge clk);
    bus.start = st; bus.start_addr = 10'(sa); bus.stall = sl; bus.branch_en = br;
    bus.branch_idx = 3'(bi); bus.ctrl_ack_out = ak; bus.lut_we = we;
    bus.lut_addr = 3'(wa); bus.lut_data = 10'(wd);
    if (mmode == 1) begin
      if (mcc < 65535) mcc++;
      if (!sl) begin
        if (ak) mmode = 2;
        else if (br) begin mpc = mlut[bi]; if (mbc < 65535) mbc++; end
        else mpc = (mpc + 1) % 1024;
      end
    end else begin
      if (we) mlut[wa] = wd;
      if (st) begin mpc = sa; mmode = 1; mcc = 0; mbc = 0; end
    end
    step++;
    x.pc = mpc; x.run = (mmode == 1); x.dn = (mmode == 2); x.step = step;
`ifdef FETCH_PERF_CNT_EN
    x.cc = mcc; x.bc = mbc;
`else
    x.cc = 0; x.bc = 0;
`endif
    exp_q.push_back(x);
  endtask

  task automatic idle();                drive(0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic go(input int sa);      drive(1, sa, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic halt();                drive(0, 0, 0, 0, 0, 1, 0, 0, 0); endtask
  task automatic jump(input int bi);    drive(0, 0, 0, 1, bi, 0, 0, 0, 0); endtask
  task automatic wr(input int a, input int d); drive(0, 0, 0, 0, 0, 0, 1, a, d); endtask

  always @(posedge clk) begin
    #1;
    if (reset_n && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("pc",         e.step, int'(bus.pc),         e.pc);
      chk("running",    e.step, int'(bus.running),    int'(e.run));
      chk("done",       e.step, int'(bus.done),       int'(e.dn));
      chk("cycle_cnt",  e.step, int'(bus.cycle_cnt),  e.cc);
      chk("branch_cnt", e.step, int'(bus.branch_cnt), e.bc);
    end
  end

  task automatic zero_inputs();
    bus.start = 0; bus.start_addr = '0; bus.stall = 0; bus.branch_en = 0;
    bus.branch_idx = '0; bus.ctrl_ack_out = 0; bus.lut_we = 0;
    bus.lut_addr = '0; bus.lut_data = '0;
  endtask

  initial begin
    zero_inputs();
    model_reset();
    #12;
    chk("rst_pc",      0, int'(bus.pc), 0);
    chk("rst_running", 0, int'(bus.running), 0);
    chk("rst_done",    0, int'(bus.done), 0);
    chk("rst_cc",      0, int'(bus.cycle_cnt), 0);
    @(negedge clk) reset_n = 1'b1;

    // Linear run from 5
    go(5); idle(); idle(); idle();
    halt(); idle();
    // Branch: table[3]=100 loaded in DONE, run from 0, branch at pc=2
    wr(3, 100);
    go(0); idle(); idle(); jump(3); idle();
    // Halt beats branch at pc=7
    halt(); go(5); idle(); idle();
    drive(0, 0, 0, 1, 3, 1, 0, 0, 0);
    idle(); idle();
    // Stall at pc=4 with branch_en asserted during the stall
    go(4);
    for (int i = 0; i < 3; i++) drive(0, 0, 1, 1, 3, 0, 0, 0, 0);
    idle(); halt();
    // Wrap and restart from DONE
    go(10'h3FF); idle(); halt(); idle();
    go(20);
    for (int i = 0; i < 30; i++) idle();

    // Async reset between edges while pc=50
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    zero_inputs();
    #1;
    chk("arst_pc",      step, int'(bus.pc), 0);
    chk("arst_running", step, int'(bus.running), 0);
    chk("arst_done",    step, int'(bus.done), 0);
    chk("arst_bc",      step, int'(bus.branch_cnt), 0);
    model_reset();
    @(negedge clk) reset_n = 1'b1;
    // Table entries must read back as 0 after reset
    go(0); idle(); jump(3); jump(0); halt();

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      if (mmode != 1) begin
        int sa;
        sa = ($urandom_range(0, 7) == 0) ? 1023 : int'($urandom_range(0, 1023));
        drive($urandom_range(0, 2) == 0, sa, 1'($urandom), 1'($urandom), int'($urandom_range(0, 7)),
              1'($urandom), 1'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(0, 1023)));
      end else begin
        drive(1'($urandom), int'($urandom_range(0, 1023)), $urandom_range(0, 3) == 0,
              $urandom_range(0, 2) == 0, int'($urandom_range(0, 7)), $urandom_range(0, 15) == 0,
              1'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(0, 1023)));
      end
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errs++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
